// File: rtl/manual_step_gen_if.sv
// Board-side bundle for the manual step generator: raw switch/button pins in,
// clock-enable, pulse and debug status out.
interface manual_step_gen_if;
    logic       manual_clk_sw;
    logic       pulse_clk_btn;
    logic       clk_en;
    logic       step_pulse;
    logic       btn_level;
    logic       manual_mode;
    logic [7:0] step_count;

    modport master (
        output manual_clk_sw,
        output pulse_clk_btn,
        input  clk_en,
        input  step_pulse,
        input  btn_level,
        input  manual_mode,
        input  step_count
    );

    modport slave (
        input  manual_clk_sw,
        input  pulse_clk_btn,
        output clk_en,
        output step_pulse,
        output btn_level,
        output manual_mode,
        output step_count
    );
endinterface

// File: rtl/manual_step_gen.sv
// manual_step_gen: synchronises the step button and manual/auto switch,
// debounces the button, and produces a single-cycle CPU clock enable per
// accepted press in manual mode (enable held high in auto mode).
module manual_step_gen #(
    parameter int CLK_PERIOD_NS = 1000,
    parameter int DEBOUNCE_NS   = 10_000_000
) (
    input  logic             clk,
    input  logic             reset,
    manual_step_gen_if.slave io
);

    localparam int DEBOUNCE_CYCLES = DEBOUNCE_NS / CLK_PERIOD_NS;
    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // A debounce window shorter than one clock period cannot be honoured
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("manual_step_gen: DEBOUNCE_NS must be at least one CLK_PERIOD_NS");
    end

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PENDING,
        PRESSED,
        RELEASE_PENDING
    } btn_state_e;

    logic             btn_meta_q, btn_meta_d;
    logic             btn_s_q, btn_s_d;
    logic             sw_meta_q, sw_meta_d;
    logic             sw_s_q, sw_s_d;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_pulse_q, step_pulse_d;
    logic             clk_en_q, clk_en_d;
    logic             btn_level_q, btn_level_d;
    logic [7:0]       step_count_q, step_count_d;

    // Next-state: synchroniser shift, debounce FSM with stability counter, pulse and enable
    always_comb begin
        btn_meta_d   = io.pulse_clk_btn;
        btn_s_d      = btn_meta_q;
        sw_meta_d    = io.manual_clk_sw;
        sw_s_d       = sw_meta_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        step_pulse_d = 1'b0;
        step_count_d = step_count_q;

        unique case (state_q)
            RELEASED: begin
                if (btn_s_q) begin
                    state_d = PRESS_PENDING;
                    cnt_d   = '0;
                end
            end
            PRESS_PENDING: begin
                if (!btn_s_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = PRESSED;
                    cnt_d        = '0;
                    step_pulse_d = 1'b1;
                    step_count_d = step_count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s_q) begin
                    state_d = RELEASE_PENDING;
                    cnt_d   = '0;
                end
            end
            RELEASE_PENDING: begin
                if (btn_s_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase

        btn_level_d = (state_d == PRESSED) || (state_d == RELEASE_PENDING);
        clk_en_d    = sw_s_q ? step_pulse_d : 1'b1;
    end

    // State and registered outputs; reset clears everything to the idle released state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_q   <= 1'b0;
            btn_s_q      <= 1'b0;
            sw_meta_q    <= 1'b0;
            sw_s_q       <= 1'b0;
            state_q      <= RELEASED;
            cnt_q        <= '0;
            step_pulse_q <= 1'b0;
            clk_en_q     <= 1'b0;
            btn_level_q  <= 1'b0;
            step_count_q <= 8'd0;
        end else begin
            btn_meta_q   <= btn_meta_d;
            btn_s_q      <= btn_s_d;
            sw_meta_q    <= sw_meta_d;
            sw_s_q       <= sw_s_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_pulse_q <= step_pulse_d;
            clk_en_q     <= clk_en_d;
            btn_level_q  <= btn_level_d;
            step_count_q <= step_count_d;
        end
    end

    assign io.clk_en      = clk_en_q;
    assign io.step_pulse  = step_pulse_q;
    assign io.btn_level   = btn_level_q;
    assign io.manual_mode = sw_s_q;
    assign io.step_count  = step_count_q;

endmodule
